// File: rtl/shift_right_seq_pkg.sv
// Shared shifter package: state encoding and data/shift-amount
// widths used by the sequential right- and left-shift blocks.
package shift_right_seq_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_right_seq_step.sv
// shift_right_1: single-bit right shift with an explicit fill bit.
// Ports: in_i (operand), fill_i (new MSB), out_o = {fill_i, in_i[W-1:1]}.
module shift_right_1 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = {fill_i, in_i[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle right shifter, one bit per clock.
// Ports: clk, rst_n, start_i/a_i/shamt_i/arith_i (request), flush_i
// (abort), busy_o (shifting), done_o (result pulse), o (last result).
module shift_right_seq
    import shift_right_seq_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               arith_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   o
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               fill_q, fill_d;
    logic [WIDTH-1:0]   step;

    shift_right_1 #(
        .WIDTH(WIDTH)
    ) u_step (
        .in_i  (work_q),
        .fill_i(fill_q),
        .out_o (step)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    work_d = a_i;
                    cnt_d  = shamt_i;
                    fill_d = arith_i & a_i[WIDTH-1];
                    if (shamt_i == '0) begin
                        // Zero shift: result is the operand itself.
                        state_d = DONE;
                        res_d   = a_i;
                    end else begin
                        state_d = SHIFT;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                work_d = step;
                cnt_d  = cnt_q - SHAMT_W'(1);
                // Last step: publish the shifted value directly.
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                    res_d   = step;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything; the published result survives.
        if (flush_i) begin
            state_d = IDLE;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
        end
    end

    assign busy_o = (state_q == SHIFT);
    assign done_o = (state_q == DONE);
    assign o      = res_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Testbench for shift_right_seq: directed scenarios plus random
// operations checked against a plain arithmetic shift model.
module tb_shift_right_seq;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [31:0] a_i;
    logic [4:0]  shamt_i;
    logic        arith_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] o;

    int          checks;
    int          failures;
    logic [31:0] exp_o;

    shift_right_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start_i),
        .a_i    (a_i),
        .shamt_i(shamt_i),
        .arith_i(arith_i),
        .flush_i(flush_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .o      (o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(
        input logic [31:0] a,
        input logic [4:0]  sh,
        input logic        ar
    );
        logic [31:0] r;
        if (ar) r = $signed(a) >>> sh;
        else    r = a >> sh;
        return r;
    endfunction

    // Called at a negedge (or just after). Starts an operation and
    // follows it to the done cycle, ending at that cycle's negedge.
    task automatic run_op(
        input logic [31:0] a,
        input logic [4:0]  sh,
        input logic        ar,
        input string       tag
    );
        logic [31:0] want;
        want    = ref_shift(a, sh, ar);
        a_i     = a;
        shamt_i = sh;
        arith_i = ar;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int k = 1; k <= int'(sh) + 1; k++) begin
            @(negedge clk);
            checks++;
            if (busy_o !== (k <= int'(sh))) begin
                failures++;
                $display("FAIL %s busy k=%0d got=%b want=%b",
                         tag, k, busy_o, (k <= int'(sh)));
            end
            checks++;
            if (done_o !== (k == int'(sh) + 1)) begin
                failures++;
                $display("FAIL %s done k=%0d got=%b want=%b",
                         tag, k, done_o, (k == int'(sh) + 1));
            end
            checks++;
            if (k <= int'(sh)) begin
                if (o !== exp_o) begin
                    failures++;
                    $display("FAIL %s o_hold k=%0d got=%h want=%h",
                             tag, k, o, exp_o);
                end
            end else begin
                if (o !== want) begin
                    failures++;
                    $display("FAIL %s result got=%h want=%h",
                             tag, o, want);
                end
            end
        end
        exp_o = want;
    endtask

    task automatic check_quiet(input string tag);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL %s quiet got busy=%b done=%b want 0/0",
                     tag, busy_o, done_o);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || o !== 32'h0) begin
            failures++;
            $display("FAIL reset_async got b=%b d=%b o=%h want 0/0/0",
                     busy_o, done_o, o);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || o !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold got b=%b d=%b o=%h want 0/0/0",
                     busy_o, done_o, o);
        end
        exp_o = 32'h0;
        // Release and start in the same cycle: first edge accepts.
        rst_n = 1'b1;
        run_op(32'h12345678, 5'd0, 1'b0, "first_start_zero");
    endtask

    task automatic test_shift_directed;
        @(negedge clk);
        run_op(32'h80000010, 5'd4, 1'b0, "logical4");
        @(negedge clk);
        run_op(32'h80000010, 5'd4, 1'b1, "arith4");
        @(negedge clk);
        run_op(32'h7000_00F0, 5'd31, 1'b1, "arith_pos31");
    endtask

    task automatic test_ignore_start;
        logic [31:0] want;
        @(negedge clk);
        want    = ref_shift(32'h80000000, 5'd31, 1'b1);
        a_i     = 32'h80000000;
        shamt_i = 5'd31;
        arith_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            checks++;
            if (done_o !== (k == 32)) begin
                failures++;
                $display("FAIL ignore_start done k=%0d got=%b want=%b",
                         k, done_o, (k == 32));
            end
            if (k == 32) begin
                checks++;
                if (o !== want) begin
                    failures++;
                    $display("FAIL ignore_start result got=%h want=%h",
                             o, want);
                end
            end
            // Extra requests with zero shift would finish at once
            // if they were (wrongly) accepted.
            if (k == 3 || k == 10) begin
                start_i = 1'b1;
                a_i     = $urandom;
                shamt_i = 5'd0;
                arith_i = 1'b0;
            end else begin
                start_i = 1'b0;
            end
        end
        exp_o = want;
    endtask

    task automatic test_flush;
        @(negedge clk);
        run_op(32'hCAFE0001, 5'd2, 1'b0, "flush_prior");
        @(negedge clk);
        a_i     = 32'h000000F0;
        shamt_i = 5'd8;
        arith_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k >= 4) begin
                check_quiet("flush_mid");
                checks++;
                if (o !== exp_o) begin
                    failures++;
                    $display("FAIL flush_keep_o k=%0d got=%h want=%h",
                             k, o, exp_o);
                end
            end
            flush_i = (k == 3);
        end
        // Flush in DONE keeps this cycle's pulse but blocks a restart.
        run_op(32'h00000100, 5'd1, 1'b0, "flush_done_op");
        flush_i = 1'b1;
        start_i = 1'b1;
        a_i     = 32'h55555555;
        shamt_i = 5'd0;
        #1;
        checks++;
        if (done_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_done_pulse got=%b want=1", done_o);
        end
        @(negedge clk);
        check_quiet("flush_prio_start");
        flush_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        check_quiet("flush_after");
        checks++;
        if (o !== exp_o) begin
            failures++;
            $display("FAIL flush_done_o got=%h want=%h", o, exp_o);
        end
    endtask

    task automatic test_reset_mid_op;
        @(negedge clk);
        a_i     = 32'h000000F0;
        shamt_i = 5'd8;
        arith_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o !== 32'h0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid got b=%b d=%b o=%h want 0/0/0",
                     busy_o, done_o, o);
        end
        exp_o = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check_quiet("rst_release");
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        run_op(32'h00000400, 5'd1, 1'b0, "b2b_first");
        run_op(32'h00000100, 5'd1, 1'b0, "b2b_second");
        run_op(32'h81234567, 5'd0, 1'b1, "b2b_zero");
        run_op(32'h80000000, 5'd3, 1'b1, "b2b_arith");
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [4:0]  sh;
        logic        ar;
        for (int i = 0; i < 60; i++) begin
            a  = $urandom;
            sh = 5'($urandom_range(31, 0));
            ar = 1'($urandom_range(1, 0));
            if ($urandom_range(1, 0) == 1) begin
                @(negedge clk);
                check_quiet("rand_gap");
            end
            run_op(a, sh, ar, "random");
        end
        @(negedge clk);
        check_quiet("rand_end");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        start_i  = 1'b0;
        a_i      = '0;
        shamt_i  = '0;
        arith_i  = 1'b0;
        flush_i  = 1'b0;
        rst_n    = 1'b0;
        exp_o    = '0;

        test_reset();
        test_shift_directed();
        test_ignore_start();
        test_flush();
        test_reset_mid_op();
        test_back_to_back();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
